// File: rtl/reg_file_sb_if.sv
// Bus bundle between the pipeline (decode/writeback) and the register file.
// The master side drives read/write addresses, writeback data and scoreboard
// sets; the slave side (the register file) returns read data, pending flags
// and the clear-in-progress stall.
interface reg_file_sb_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 5
);
  logic              reg_write;
  logic [ADDR_W-1:0] rd_addr;
  logic [XLEN-1:0]   write_data;
  logic [ADDR_W-1:0] rs1_addr;
  logic [ADDR_W-1:0] rs2_addr;
  logic [XLEN-1:0]   rs1_data_out;
  logic [XLEN-1:0]   rs2_data_out;
  logic              sb_set;
  logic [ADDR_W-1:0] sb_addr;
  logic              rs1_pending;
  logic              rs2_pending;
  logic              clr_busy;

  modport master (
    output reg_write, rd_addr, write_data, rs1_addr, rs2_addr, sb_set, sb_addr,
    input  rs1_data_out, rs2_data_out, rs1_pending, rs2_pending, clr_busy
  );

  modport slave (
    input  reg_write, rd_addr, write_data, rs1_addr, rs2_addr, sb_set, sb_addr,
    output rs1_data_out, rs2_data_out, rs1_pending, rs2_pending, clr_busy
  );
endinterface

// File: rtl/reg_file_sb.sv
// Integer register file with two combinational read ports, one write port,
// a post-reset clear sequencer that zeroes every entry one per cycle, an
// optional writeback-to-read bypass and a per-register pending scoreboard
// used by decode to spot RAW hazards against in-flight producers.
// NREGS must be a power of two equal to 2**ADDR_W.
module reg_file_sb #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int ADDR_W   = 5,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  reg_file_sb_if.slave  bus
);

  localparam logic L_BYPASS = (BYPASS != 0);
  localparam logic L_ZERO   = (ZERO_REG != 0);

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic              r_clrBusy;
  logic [XLEN-1:0]   r_mem [NREGS];
  logic [NREGS-1:0]  r_pending;

  logic              w_commit;
  logic              w_set;
  logic [NREGS-1:0]  w_clrMask;
  logic [NREGS-1:0]  w_setMask;
  logic              w_rs1Zero;
  logic              w_rs2Zero;
  logic              w_rs1Fwd;
  logic              w_rs2Fwd;

  // A writeback or scoreboard set only counts once the clear has finished,
  // and never for register 0 when it is hardwired to zero.
  always_comb begin
    w_commit  = !r_clrBusy && bus.reg_write && !(L_ZERO && (bus.rd_addr == '0));
    w_set     = !r_clrBusy && bus.sb_set && !(L_ZERO && (bus.sb_addr == '0));
    w_clrMask = w_commit ? (NREGS'(1) << bus.rd_addr) : '0;
    w_setMask = w_set ? (NREGS'(1) << bus.sb_addr) : '0;
    w_rs1Zero = L_ZERO && (bus.rs1_addr == '0);
    w_rs2Zero = L_ZERO && (bus.rs2_addr == '0);
    w_rs1Fwd  = L_BYPASS && w_commit && (bus.rd_addr == bus.rs1_addr);
    w_rs2Fwd  = L_BYPASS && w_commit && (bus.rd_addr == bus.rs2_addr);
  end

  // Clear sequencer: walk the pointer over every entry after reset, then run.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_CLEAR;
      r_ptr     <= '0;
      r_clrBusy <= 1'b1;
    end else begin
      case (r_state)
        S_CLEAR: begin
          r_ptr <= r_ptr + ADDR_W'(1);
          if (r_ptr == ADDR_W'(NREGS - 1)) begin
            r_state   <= S_RUN;
            r_clrBusy <= 1'b0;
          end
        end
        S_RUN: begin
          r_state   <= S_RUN;
          r_clrBusy <= 1'b0;
        end
        default: begin
          r_state   <= S_CLEAR;
          r_ptr     <= '0;
          r_clrBusy <= 1'b1;
        end
      endcase
    end
  end

  // Storage: the sequencer zeroes one entry per cycle, otherwise writeback lands.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (r_clrBusy) begin
        r_mem[r_ptr] <= '0;
      end else if (w_commit) begin
        r_mem[bus.rd_addr] <= bus.write_data;
      end
    end
  end

  // Scoreboard: writeback clears its destination, a new issue sets it; a set
  // wins over a clear of the same register because the newer producer is pending.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pending <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clrMask) | w_setMask;
    end
  end

  // Read ports: zero while clearing or for x0, forwarded writeback data when
  // bypassing, otherwise the stored value; pending is masked the same way.
  always_comb begin
    bus.clr_busy = r_clrBusy;

    if (r_clrBusy || w_rs1Zero) begin
      bus.rs1_data_out = '0;
      bus.rs1_pending  = 1'b0;
    end else if (w_rs1Fwd) begin
      bus.rs1_data_out = bus.write_data;
      bus.rs1_pending  = 1'b0;
    end else begin
      bus.rs1_data_out = r_mem[bus.rs1_addr];
      bus.rs1_pending  = r_pending[bus.rs1_addr];
    end

    if (r_clrBusy || w_rs2Zero) begin
      bus.rs2_data_out = '0;
      bus.rs2_pending  = 1'b0;
    end else if (w_rs2Fwd) begin
      bus.rs2_data_out = bus.write_data;
      bus.rs2_pending  = 1'b0;
    end else begin
      bus.rs2_data_out = r_mem[bus.rs2_addr];
      bus.rs2_pending  = r_pending[bus.rs2_addr];
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: a default instance (BYPASS=1), a
// non-bypassing instance and a 16 x 64-bit instance share clock and reset.
module tb_reg_file_sb;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checkCount = 0;
  int   errorCount = 0;
  int   cntA;
  int   cntC;

  always #5 clk = ~clk;

  reg_file_sb_if #(.XLEN(32), .ADDR_W(5)) busA ();
  reg_file_sb_if #(.XLEN(32), .ADDR_W(5)) busB ();
  reg_file_sb_if #(.XLEN(64), .ADDR_W(4)) busC ();

  reg_file_sb #(.XLEN(32), .NREGS(32), .ADDR_W(5), .BYPASS(1), .ZERO_REG(1))
    dutA (.clk(clk), .rst_n(rst_n), .bus(busA.slave));
  reg_file_sb #(.XLEN(32), .NREGS(32), .ADDR_W(5), .BYPASS(0), .ZERO_REG(1))
    dutB (.clk(clk), .rst_n(rst_n), .bus(busB.slave));
  reg_file_sb #(.XLEN(64), .NREGS(16), .ADDR_W(4), .BYPASS(1), .ZERO_REG(1))
    dutC (.clk(clk), .rst_n(rst_n), .bus(busC.slave));

  // Compare one observed value against its expected value and log mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Drive every input of the default instance, then let the reads settle.
  task automatic applyStimulus(input logic we, input logic [4:0] rd,
                               input logic [31:0] wdata, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic set,
                               input logic [4:0] sbAddr);
    busA.reg_write  = we;
    busA.rd_addr    = rd;
    busA.write_data = wdata;
    busA.rs1_addr   = rs1;
    busA.rs2_addr   = rs2;
    busA.sb_set     = set;
    busA.sb_addr    = sbAddr;
    #1;
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Count sampled clr_busy cycles of instances A and C, bounded.
  task automatic waitClear(output int nA, output int nC);
    nA = 0;
    nC = 0;
    for (int k = 0; k < 100; k++) begin
      if (!busA.clr_busy && !busC.clr_busy) break;
      if (busA.clr_busy) nA++;
      if (busC.clr_busy) nC++;
      tick();
    end
  endtask

  initial begin
    busB.reg_write = 0; busB.rd_addr = '0; busB.write_data = '0;
    busB.rs1_addr = '0; busB.rs2_addr = '0; busB.sb_set = 0; busB.sb_addr = '0;
    busC.reg_write = 0; busC.rd_addr = '0; busC.write_data = '0;
    busC.rs1_addr = '0; busC.rs2_addr = '0; busC.sb_set = 0; busC.sb_addr = '0;
    applyStimulus(0, 0, 0, 0, 5, 0, 0);

    // Reset state
    tick();
    tick();
    checkOutput("rst_busy", 64'(busA.clr_busy), 64'd1);
    checkOutput("rst_rs2_data", 64'(busA.rs2_data_out), 64'd0);
    checkOutput("rst_rs1_pend", 64'(busA.rs1_pending), 64'd0);
    checkOutput("rst_rs2_pend", 64'(busA.rs2_pending), 64'd0);
    rst_n = 1'b1;
    waitClear(cntA, cntC);
    checkOutput("init_clear_len_A", 64'(cntA), 64'd32);
    checkOutput("init_clear_len_C", 64'(cntC), 64'd16);

    // Preload every register with a nonzero value
    for (int i = 1; i < 32; i++) begin
      applyStimulus(1, 5'(i), 32'h1000_0000 + 32'(i), 0, 0, 0, 0);
      tick();
    end
    applyStimulus(0, 0, 0, 5, 0, 0, 0);
    checkOutput("preload_x5", 64'(busA.rs1_data_out), 64'h1000_0005);

    // Reset for 3 cycles, then clear while writes and sets are attempted
    rst_n = 1'b0;
    tick(); tick(); tick();
    applyStimulus(1, 1, 32'hFFFF_FFFF, 1, 2, 1, 2);
    rst_n = 1'b1;
    #1;
    checkOutput("clear_rd_forced0", 64'(busA.rs1_data_out), 64'd0);
    checkOutput("clear_pend_forced0", 64'(busA.rs2_pending), 64'd0);
    waitClear(cntA, cntC);
    applyStimulus(0, 0, 0, 1, 2, 0, 0);
    checkOutput("clear_len_A", 64'(cntA), 64'd32);
    checkOutput("clear_write_ignored", 64'(busA.rs1_data_out), 64'd0);
    checkOutput("clear_set_ignored", 64'(busA.rs2_pending), 64'd0);
    for (int i = 2; i < 32; i++) begin
      applyStimulus(0, 0, 0, 5'(i), 0, 0, 0);
      checkOutput($sformatf("cleared_x%0d", i), 64'(busA.rs1_data_out), 64'd0);
    end

    // Basic write/read and x0
    applyStimulus(1, 5, 32'hDEAD_BEEF, 0, 0, 0, 0);
    tick();
    applyStimulus(1, 0, 32'h0000_1234, 0, 0, 0, 0);
    checkOutput("x0_no_bypass", 64'(busA.rs1_data_out), 64'd0);
    tick();
    applyStimulus(0, 0, 0, 5, 0, 0, 0);
    checkOutput("rd_x5", 64'(busA.rs1_data_out), 64'hDEAD_BEEF);
    checkOutput("rd_x0", 64'(busA.rs2_data_out), 64'd0);

    // Bypass on A: new data visible the same cycle
    applyStimulus(1, 7, 32'h0000_1111, 0, 0, 0, 0);
    tick();
    applyStimulus(1, 7, 32'hA5A5_A5A5, 7, 7, 0, 0);
    checkOutput("byp_rs1", 64'(busA.rs1_data_out), 64'hA5A5_A5A5);
    checkOutput("byp_rs2", 64'(busA.rs2_data_out), 64'hA5A5_A5A5);
    tick();
    applyStimulus(0, 0, 0, 7, 7, 0, 0);
    checkOutput("byp_stored", 64'(busA.rs1_data_out), 64'hA5A5_A5A5);

    // No bypass on B: old value first, new value one cycle later
    busB.reg_write = 1; busB.rd_addr = 7; busB.write_data = 32'h0000_1111;
    tick();
    busB.write_data = 32'hA5A5_A5A5; busB.rs1_addr = 7; busB.rs2_addr = 7;
    #1;
    checkOutput("nobyp_rs1_old", 64'(busB.rs1_data_out), 64'h0000_1111);
    checkOutput("nobyp_rs2_old", 64'(busB.rs2_data_out), 64'h0000_1111);
    tick();
    busB.reg_write = 0;
    #1;
    checkOutput("nobyp_rs1_new", 64'(busB.rs1_data_out), 64'hA5A5_A5A5);
    checkOutput("nobyp_rs2_new", 64'(busB.rs2_data_out), 64'hA5A5_A5A5);

    // Scoreboard set, writeback clear, x0 set dropped
    applyStimulus(0, 0, 0, 9, 0, 1, 9);
    tick();
    applyStimulus(0, 0, 0, 9, 0, 0, 0);
    checkOutput("sb_x9_set", 64'(busA.rs1_pending), 64'd1);
    applyStimulus(1, 9, 32'h0000_0099, 9, 0, 0, 0);
    checkOutput("sb_x9_wb_same", 64'(busA.rs1_pending), 64'd0);
    checkOutput("sb_x9_wb_data", 64'(busA.rs1_data_out), 64'h0000_0099);
    tick();
    applyStimulus(0, 0, 0, 9, 0, 1, 0);
    checkOutput("sb_x9_wb_after", 64'(busA.rs1_pending), 64'd0);
    tick();
    applyStimulus(0, 0, 0, 9, 0, 0, 0);
    checkOutput("sb_x0_set", 64'(busA.rs2_pending), 64'd0);

    // Simultaneous set and clear
    applyStimulus(0, 0, 0, 3, 0, 1, 3);
    tick();
    applyStimulus(1, 3, 32'h0000_0033, 3, 0, 1, 3);
    checkOutput("sim_same_fwd_pend", 64'(busA.rs1_pending), 64'd0);
    tick();
    applyStimulus(0, 0, 0, 3, 0, 0, 0);
    checkOutput("sim_same_set_wins", 64'(busA.rs1_pending), 64'd1);
    applyStimulus(1, 3, 32'h0000_0034, 4, 3, 1, 4);
    tick();
    applyStimulus(0, 0, 0, 4, 3, 0, 0);
    checkOutput("sim_diff_x4_set", 64'(busA.rs1_pending), 64'd1);
    checkOutput("sim_diff_x3_clr", 64'(busA.rs2_pending), 64'd0);
    checkOutput("sim_diff_x3_data", 64'(busA.rs2_data_out), 64'h0000_0034);

    // Reset mid-run: x12 pending with data, C holds 64-bit data in x15
    applyStimulus(1, 12, 32'h0000_0055, 0, 0, 0, 0);
    busC.reg_write = 1; busC.rd_addr = 15; busC.write_data = 64'h0123_4567_89AB_CDEF;
    tick();
    applyStimulus(0, 0, 0, 12, 0, 1, 12);
    busC.reg_write = 0; busC.rs1_addr = 15;
    tick();
    applyStimulus(0, 0, 0, 12, 0, 0, 0);
    checkOutput("mid_x12_pend", 64'(busA.rs1_pending), 64'd1);
    checkOutput("mid_x12_data", 64'(busA.rs1_data_out), 64'h0000_0055);
    checkOutput("mid_C_x15_data", busC.rs1_data_out, 64'h0123_4567_89AB_CDEF);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    checkOutput("mid_pend_cleared", 64'(busA.rs1_pending), 64'd0);
    checkOutput("mid_busy", 64'(busA.clr_busy), 64'd1);
    waitClear(cntA, cntC);
    checkOutput("mid_clear_len_A", 64'(cntA), 64'd32);
    checkOutput("mid_clear_len_C", 64'(cntC), 64'd16);
    applyStimulus(0, 0, 0, 12, 0, 0, 0);
    checkOutput("mid_x12_zero", 64'(busA.rs1_data_out), 64'd0);
    checkOutput("mid_x12_pend_after", 64'(busA.rs1_pending), 64'd0);
    checkOutput("mid_C_x15_zero", busC.rs1_data_out, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised integer register file for the BRISC-V pipeline with configurable data width and register count.
- Adds the following to the basic two-read/one-write file:
  - a post-reset hardware clear sequencer;
  - an optional write-to-read bypass;
  - a per-register pending scoreboard so decode can detect RAW hazards against in-flight producers.
- Sits between decode (read ports, scoreboard set) and writeback (write port, scoreboard clear).

Parameters:
- XLEN, 32: data width of every register and data port.
- NREGS, 32: number of architectural registers; power of two, >=2.
- ADDR_W, 5: address width; must equal log2(NREGS).
- BYPASS, 1: 1 = same-cycle writeback data forwarded to read ports; 0 = reads return stored value only.
- ZERO_REG, 1: 1 = register 0 hardwired to zero (reads 0, writes and scoreboard sets dropped); 0 = register 0 is ordinary.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- reg_write  input  1  writeback enable.
- rd_addr  input  ADDR_W  writeback destination.
- write_data  input  XLEN  writeback data.
- rs1_addr  input  ADDR_W  read port 1 address.
- rs2_addr  input  ADDR_W  read port 2 address.
- rs1_data_out  output  XLEN  read port 1 data (combinational).
- rs2_data_out  output  XLEN  read port 2 data (combinational).
- sb_set  input  1  mark sb_addr as pending (instruction issued with a destination).
- sb_addr  input  ADDR_W  register to mark pending.
- rs1_pending  output  1  rs1_addr has an outstanding producer.
- rs2_pending  output  1  rs2_addr has an outstanding producer.
- clr_busy  output  1  clear sequence in progress; pipeline must stall.

Behaviour:
- Reset is synchronous and active-low: sampling rst_n=0 at a rising edge of clk resets the block.
  - State goes to CLEAR, clear pointer to 0, all pending bits to 0.
  - rst_n is held low for any number of cycles: the block stays in CLEAR with pointer 0.
- Output values after reset:
  - clr_busy=1.
  - rs1_data_out and rs2_data_out = 0, forced while clr_busy=1.
  - rs1_pending and rs2_pending = 0.
- State machine, two states:
  - CLEAR: each edge with rst_n=1 writes 0 to mem[ptr] and increments ptr. The edge that writes ptr=NREGS-1 moves the state to RUN. The clear therefore takes exactly NREGS cycles after rst_n rises.
  - RUN: normal operation. The block stays in RUN until the next reset.
  - Reset asserted mid-CLEAR or mid-RUN restarts CLEAR from pointer 0.
- clr_busy = (state==CLEAR), registered.
- While in CLEAR:
  - reg_write and sb_set are ignored.
  - Pending outputs read 0.
- Write (RUN only):
  - At the edge where reg_write=1, mem[rd_addr] <= write_data.
  - Dropped if ZERO_REG=1 and rd_addr=0.
- Read (combinational):
  - rsX_data_out = 0 if ZERO_REG=1 and rsX_addr=0.
  - Otherwise, if BYPASS=1 and reg_write=1 and rd_addr==rsX_addr, it equals write_data.
  - Otherwise it equals mem[rsX_addr].
  - Both ports are independent; rs1_addr==rs2_addr is legal.
- Scoreboard, NREGS pending bits, RUN only:
  - sb_set=1 sets pending[sb_addr]; ignored for address 0 when ZERO_REG=1.
  - A committed write (reg_write=1, not dropped) clears pending[rd_addr].
  - Set and clear to the same address on the same edge: set wins and the bit stays 1 (newer producer in flight).
  - Set and clear to different addresses on the same edge: both take effect.
  - Setting an already-pending bit keeps it at 1; no counting.
- Pending outputs:
  - rsX_pending = pending[rsX_addr].
  - Forced 0 when ZERO_REG=1 and rsX_addr=0.
  - When BYPASS=1, forced 0 if a committed write to rsX_addr occurs in the same cycle, because the data is being forwarded.
- Width rules:
  - Addresses are unsigned and always in range, since NREGS=2^ADDR_W.
  - No arithmetic on data; values are stored verbatim at XLEN bits.

Test Plan:
- Reset/clear: preload via writes, pulse rst_n low 3 cycles, release.
  - Required: clr_busy=1 for exactly 32 cycles, then 0.
  - After clear, reads of regs 1..31 return 0.
  - Writes issued during clear have no effect.
- Basic write/read and x0: write 32'hDEADBEEF to x5 and 32'h1234 to x0; read rs1=5, rs2=0.
  - Required: rs1_data_out=32'hDEADBEEF, rs2_data_out=0.
- Bypass: with BYPASS=1, write 32'hA5A5A5A5 to x7 while rs1=rs2=7 in the same cycle.
  - Required: both outputs = 32'hA5A5A5A5 that cycle.
  - Rerun with BYPASS=0: the same cycle shows the old value and the next cycle shows 32'hA5A5A5A5.
- Scoreboard set/clear:
  - sb_set x9, then read rs1=9 → rs1_pending=1.
  - Writeback to x9 → pending 0 that cycle (BYPASS=1) and afterwards.
  - sb_set x0 → rs2_pending stays 0 with rs2=0.
- Simultaneous set/clear: x3 pending; in one cycle sb_set x3 and write x3.
  - Required: x3 still pending next cycle.
  - Same cycle with sb_set x4 and write x3: x4 pending, x3 clear.
- Reset mid-run: x12 pending and holding 32'h55; assert rst_n low 1 cycle.
  - Required: pending cleared immediately, clr_busy=1 for 32 cycles, x12 reads 0 afterwards.
  - Repeat with NREGS=16, ADDR_W=4, XLEN=64: clear takes 16 cycles.
